// File: rtl/cubic_pkg.sv
// Shared phase codes, state encoding and widths for the bicubic sequencer.
package cubic_pkg;

    localparam logic [2:0] CNT_MIX  = 3'd0;
    localparam logic [2:0] CNT_T0   = 3'd1;
    localparam logic [2:0] CNT_T1   = 3'd2;
    localparam logic [2:0] CNT_T2   = 3'd3;
    localparam logic [2:0] CNT_T3   = 3'd4;
    localparam logic [2:0] CNT_HOLD = 3'd5;

    localparam int WGT_W = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_TAP,
        S_MIX
    } state_t;

endpackage

// File: rtl/cubic_addr_gen.sv
// Running base/tap address accumulator; tap addresses are built by repeated
// stride addition so no multiplier is needed. Arithmetic wraps at 2^ADDR_W.
module cubic_addr_gen #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] tap_stride,
    input  logic [ADDR_W-1:0] out_stride,
    input  logic              next_tap,
    input  logic              next_out,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] ts, os, base, tap, next_base;

    assign next_base = base + os;
    // While stepping to the next sample the fresh base is presented directly,
    // so the following sample's tap 0 read happens in the same cycle.
    assign addr = next_out ? next_base : tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts   <= '0;
            os   <= '0;
            base <= '0;
            tap  <= '0;
        end else if (load) begin
            ts   <= tap_stride;
            os   <= out_stride;
            base <= src;
            tap  <= src;
        end else if (next_out) begin
            base <= next_base;
            tap  <= next_base + ts;
        end else if (next_tap) begin
            tap  <= tap + ts;
        end
    end

endmodule

// File: rtl/cubic_seq_ctrl.sv
// Sequencer that turns one start command into a run of bicubic samples,
// fetching four taps per sample and driving the Cubic_engine phase codes.
module cubic_seq_ctrl
    import cubic_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] tap_stride,
    input  logic [ADDR_W-1:0] out_stride,
    input  logic [LEN_W-1:0]  num_out,
    input  logic [WGT_W-1:0]  wgt_in,
    output logic [LEN_W-1:0]  out_idx,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        eng_cnt,
    output logic [WGT_W-1:0]  eng_x,
    output logic [7:0]        eng_p,
    input  logic [7:0]        eng_out,
    output logic              res_valid,
    output logic [7:0]        res_data,
    output logic [LEN_W-1:0]  res_idx,
    output logic              busy,
    output logic              done
);

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [LEN_W-1:0]  idx, idx_n, num, res_idx_n;
    logic              res_valid_n, done_n, tail, tail_n;
    logic              load, next_tap, next_out;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W:0]    idx_inc;
    logic              more;

    assign idx_inc = {1'b0, idx} + {{LEN_W{1'b0}}, 1'b1};
    assign more    = idx_inc < {1'b0, num};

    cubic_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .src        (src_addr),
        .tap_stride (tap_stride),
        .out_stride (out_stride),
        .next_tap   (next_tap),
        .next_out   (next_out),
        .addr       (addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            num       <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            done      <= 1'b0;
            tail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            res_valid <= res_valid_n;
            res_idx   <= res_idx_n;
            done      <= done_n;
            tail      <= tail_n;
            if (load) num <= num_out;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        res_valid_n = 1'b0;
        res_idx_n   = res_idx;
        done_n      = 1'b0;
        tail_n      = 1'b0;
        load        = 1'b0;
        next_tap    = 1'b0;
        next_out    = 1'b0;
        mem_ren     = 1'b0;
        eng_cnt     = CNT_HOLD;
        eng_x       = '0;
        eng_p       = '0;
        out_idx     = '0;
        unique case (state)
            S_IDLE: begin
                // tail marks the done cycle of a real run, where start is ignored
                if (start && !tail) begin
                    if (num_out != '0) begin
                        state_n = S_LOAD;
                        idx_n   = '0;
                        load    = 1'b1;
                    end else begin
                        done_n  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                eng_cnt  = CNT_MIX;
                eng_x    = wgt_in;
                out_idx  = idx;
                mem_ren  = 1'b1;
                next_tap = 1'b1;
                state_n  = S_TAP;
                cnt_n    = CNT_T0;
            end
            S_TAP: begin
                eng_cnt = cnt;
                eng_p   = mem_rdata;
                if (cnt != CNT_T3) begin
                    mem_ren  = 1'b1;
                    next_tap = 1'b1;
                    cnt_n    = cnt + 3'd1;
                end else begin
                    state_n  = S_MIX;
                end
            end
            S_MIX: begin
                eng_cnt     = CNT_MIX;
                next_out    = 1'b1;
                res_valid_n = 1'b1;
                res_idx_n   = idx;
                if (more) begin
                    eng_x   = wgt_in;
                    out_idx = idx_inc[LEN_W-1:0];
                    mem_ren = 1'b1;
                    idx_n   = idx_inc[LEN_W-1:0];
                    state_n = S_TAP;
                    cnt_n   = CNT_T0;
                end else begin
                    done_n  = 1'b1;
                    tail_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign mem_addr = mem_ren ? addr : '0;
    assign res_data = res_valid ? eng_out : 8'd0;
    assign busy     = (state != S_IDLE) || tail;

endmodule

// File: tb/tb_cubic_seq_ctrl.sv
// Scoreboard bench for cubic_seq_ctrl with a behavioural memory and engine.
module tb_cubic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] src_addr, tap_stride, out_stride;
    logic [7:0]  num_out;
    logic [23:0] wgt_in;
    logic [7:0]  out_idx;
    logic        mem_ren;
    logic [13:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [2:0]  eng_cnt;
    logic [23:0] eng_x;
    logic [7:0]  eng_p;
    logic [7:0]  eng_out;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [7:0]  res_idx;
    logic        busy;
    logic        done;

    cubic_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
        .tap_stride(tap_stride), .out_stride(out_stride), .num_out(num_out),
        .wgt_in(wgt_in), .out_idx(out_idx), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .eng_cnt(eng_cnt),
        .eng_x(eng_x), .eng_p(eng_p), .eng_out(eng_out),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] idx;
        logic       last;
    } res_t;

    logic [13:0] aq[$];
    res_t        rq[$];
    logic [7:0]  mem [0:16383];
    logic [23:0] wtab [0:7];
    int checks = 0, failures = 0;
    int cyc = 0, load_cyc = 0, done_cyc = 0, done_cnt = 0, prev_cyc = 0;
    int bare_exp = 0;
    bit have_prev = 0, busy_d = 0;

    assign wgt_in = wtab[out_idx[2:0]];

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    // Catmull-Rom engine: weights {x^3, x^2, x} in Q0.8, result latched on phase 0.
    function automatic logic [7:0] cub(input int pm, p0, p1, p2, input logic [23:0] x);
        int a1, a2, a3, s;
        a1 = p1 - pm;
        a2 = 2*pm - 5*p0 + 4*p1 - p2;
        a3 = -pm + 3*p0 - 3*p1 + p2;
        s  = (512*p0 + a1*int'(x[7:0]) + a2*int'(x[15:8]) + a3*int'(x[23:16])) / 512;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    int pr[4];
    logic [23:0] xr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_out <= 8'd0;
            xr      <= 24'd0;
        end else if (eng_cnt == 3'd0) begin
            eng_out <= cub(pr[0], pr[1], pr[2], pr[3], xr);
            xr      <= eng_x;
        end else if (eng_cnt <= 3'd4) begin
            pr[int'(eng_cnt) - 1] <= int'(eng_p);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !busy_d) load_cyc = cyc;
            busy_d = busy;
            if (mem_ren) begin
                if (aq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read actual=%0d required=none", mem_addr);
                end else begin
                    chk("read_addr", int'(mem_addr), int'(aq.pop_front()));
                end
            end
            if (res_valid) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result actual=%0d required=none", res_data);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("res_data", res_data, r.data);
                    chk("res_idx", res_idx, r.idx);
                    chk("done_with_last", done, r.last);
                    if (have_prev) chk("res_spacing", cyc - prev_cyc, 5);
                    prev_cyc  = cyc;
                    have_prev = !r.last;
                    if (r.last) chk("busy_in_done", busy, 1);
                end
            end else if (done) begin
                chk("bare_done_expected", int'(bare_exp > 0), 1);
                if (bare_exp > 0) bare_exp--;
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_eng_cnt"}, eng_cnt, 5);
        chk({tag, "_mem_ren"}, mem_ren, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_eng_x"}, eng_x, 0);
        chk({tag, "_eng_p"}, eng_p, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic pulse_start(input logic [13:0] src, ts, os, input logic [7:0] n);
        @(posedge clk); #1;
        src_addr = src; tap_stride = ts; out_stride = os; num_out = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [13:0] src, ts, os, input logic [7:0] n, input bit poke);
        logic [13:0] b;
        int target, t;
        for (int i = 0; i < int'(n); i++) begin
            b = src + 14'(i) * os;
            for (int k = 0; k < 4; k++) aq.push_back(b + 14'(k) * ts);
        end
        target = done_cnt + 1;
        pulse_start(src, ts, os, n);
        if (poke) begin
            repeat (7) @(posedge clk);
            #1; start = 1'b1; src_addr = 14'd5000; num_out = 8'd1;
            @(posedge clk); #1; start = 1'b0;
        end
        t = 0;
        while (done_cnt < target && t < 400) begin
            @(posedge clk); t++;
        end
        chk("done_seen", int'(done_cnt >= target), 1);
        chk("run_len", done_cyc - load_cyc, 5 * int'(n) + 1);
        chk("queues_drained", aq.size() + rq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
        for (int i = 0; i < 8; i++) wtab[i] = 24'd0;
        rst = 1'b1; start = 1'b0; src_addr = '0; tap_stride = '0;
        out_stride = '0; num_out = '0;
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) rst = 1'b0;

        // single sample, x = 0.5 on linear data
        mem[100] = 8'd10; mem[101] = 8'd20; mem[102] = 8'd30; mem[103] = 8'd40;
        wtab[0] = {8'd32, 8'd64, 8'd128};
        rq.push_back('{8'd25, 8'd0, 1'b1});
        run(14'd100, 14'd1, 14'd1, 8'd1, 0);

        // zero weights give tap P(0)
        wtab[0] = 24'd0;
        rq.push_back('{8'd20, 8'd0, 1'b1});
        run(14'd100, 14'd1, 14'd1, 8'd1, 0);

        // vertical pass over rows of 10*r + col, with an ignored start mid-run
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++) mem[128*r + c] = 8'(10*r + c);
        wtab[0] = 24'd0; wtab[1] = {8'd32, 8'd64, 8'd128}; wtab[2] = 24'd0;
        rq.push_back('{8'd10, 8'd0, 1'b0});
        rq.push_back('{8'd16, 8'd1, 1'b0});
        rq.push_back('{8'd12, 8'd2, 1'b1});
        run(14'd0, 14'd128, 14'd1, 8'd3, 1);

        // num_out = 0: done next cycle, no reads
        bare_exp = 1;
        pulse_start(14'd300, 14'd1, 14'd1, 8'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        @(posedge clk); #1;
        chk("zero_done_off", done, 0);
        repeat (3) @(posedge clk);
        chk("zero_done_consumed", bare_exp, 0);

        // wrap-around addressing
        mem[16382] = 8'd50; mem[16383] = 8'd60; mem[0] = 8'd70; mem[1] = 8'd80;
        wtab[0] = 24'd0;
        rq.push_back('{8'd60, 8'd0, 1'b1});
        run(14'd16382, 14'd1, 14'd1, 8'd1, 0);

        // abort at TAP cnt=3, then a clean run
        wtab[0] = {8'd32, 8'd64, 8'd128};
        for (int k = 0; k < 4; k++) aq.push_back(14'd100 + 14'(k));
        pulse_start(14'd100, 14'd1, 14'd1, 8'd1);
        repeat (3) @(posedge clk);
        #1 chk("abort_at_tap3", eng_cnt, 3);
        rst = 1'b1;
        #1 check_idle("abort");
        aq.delete(); rq.delete(); have_prev = 0;
        repeat (2) @(posedge clk);
        #1 chk("abort_no_res", res_valid, 0);
        chk("abort_no_done", done, 0);
        @(negedge clk) rst = 1'b0;
        rq.push_back('{8'd25, 8'd0, 1'b1});
        run(14'd100, 14'd1, 14'd1, 8'd1, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cubic_seq_ctrl.md
# cubic_seq_ctrl

Sequencer for the bicubic `Cubic_engine` datapath. It turns one `start` command into a run of `num_out` interpolated samples. For each sample it fetches four taps from image memory, drives the engine's `cycle_cnt` phase sequence and feeds pixels to `P_in` and the weight vector to `X_in`. It then returns each engine result with an index. It sits between the scaler's top-level FSM and `Cubic_engine`, and runs both horizontal passes (tap_stride = 1) and vertical passes (tap_stride = image width).

## Interface
- `ADDR_W`, default 14: image-memory address width (128×128 byte image).
- `LEN_W`, default 8: width of sample count and index.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset; also wired to the engine's `rst`.
- `start` in 1: one-cycle command strobe; sampled only in IDLE.
- `src_addr` in ADDR_W: address of tap P(-1) for sample 0.
- `tap_stride` in ADDR_W: address step between taps.
- `out_stride` in ADDR_W: step of the tap-0 address between successive samples.
- `num_out` in LEN_W: number of samples in the run.
- `wgt_in` in 24: {X2,X1,X0} Q0.8 weights for sample `out_idx`; supplied combinationally by upstream.
- `out_idx` out LEN_W: index of the sample whose weights are being loaded.
- `mem_ren` out 1: memory read enable.
- `mem_addr` out ADDR_W: read address.
- `mem_rdata` in 8: read data; valid exactly one cycle after `mem_ren`.
- `eng_cnt` out 3: drives engine `cycle_cnt`.
- `eng_x` out 24: drives engine `X_in`.
- `eng_p` out 8: drives engine `P_in`.
- `eng_out` in 8: engine `out`.
- `res_valid` out 1: result strobe.
- `res_data` out 8: the result.
- `res_idx` out LEN_W: index of the result.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle end-of-run pulse.

## Operation
- States: IDLE, LOAD (`eng_cnt`=0), TAP (`eng_cnt`=1..4), MIX (`eng_cnt`=0).
- IDLE:
  - `eng_cnt`=5 (engine hold code); `mem_ren`=0.
  - `start` with `num_out`≠0 → LOAD; latch `src_addr`, `tap_stride`, `out_stride`, `num_out`; base←src_addr, idx←0.
  - `start` with `num_out`=0 → assert `done` the next cycle, stay IDLE, issue no reads.
- LOAD (one cycle): `eng_x`=`wgt_in`, `out_idx`=idx, `mem_ren`=1, `mem_addr`=base → TAP with cnt=1.
- TAP, cnt = k (1..4):
  - `eng_p`=`mem_rdata` (tap k-1).
  - For k≤3: `mem_ren`=1, `mem_addr`=base+k·tap_stride.
  - k=4 → MIX.
- MIX:
  - The engine computes the result; base←base+out_stride.
  - If idx+1 < num_out: drive `eng_x`=`wgt_in`, `out_idx`=idx+1, `mem_ren`=1, `mem_addr`=new base, idx←idx+1, go to TAP cnt=1. MIX doubles as LOAD for the next sample.
  - Otherwise → IDLE.
- Results:
  - `res_valid`=1 in the cycle after each MIX; `res_data`=`eng_out`; `res_idx`= the index of the sample just mixed.
  - `done` coincides with the last `res_valid`.
- `start` while `busy` is ignored.
- Address arithmetic is modulo 2^ADDR_W. Tap addresses come from a running accumulator (base, base+ts, +2ts, +3ts); there is no multiplier.
- `eng_x` is 0 and `eng_p` is 0 outside the cycles listed above.

## Timing
- Reset value of every output is 0, except `eng_cnt`=5. Reset asserted mid-run aborts immediately to IDLE: no `done`, no `res_valid`.
- Cycle numbering: `start` sampled at edge E, LOAD at cycle E+1=T0, TAP T1..T4, MIX T5, first `res_valid` at T6.
- Steady state is 5 cycles per sample. Sample n's `res_valid` is at T0+6+5n, and it overlaps the next sample's TAP cnt=1.
- A run of N samples takes 5N+1 cycles from LOAD to `done`.
- `busy`=1 from T0 through the `done` cycle inclusive. A `start` in the `done` cycle is ignored; IDLE is re-entered the next cycle.
- `mem_rdata` is used without a register stage (`eng_p` is combinational from `mem_rdata`).

## Structure
- Shared package `cubic_pkg` holds:
  - Phase codes CNT_MIX=0, CNT_T0..CNT_T3=1..4, CNT_HOLD=5.
  - The state enum.
  - WGT_W=24.
- One sub-module, `cubic_addr_gen`: base/tap accumulator with `load`, `next_tap` and `next_out` controls.

## Test plan
- Single sample:
  - Stimulus: `src_addr`=100, `tap_stride`=1; memory[100..103]=10,20,30,40; `wgt_in`={32,64,128}.
  - Required: `res_data`=25, `res_idx`=0, `res_valid` and `done` at T0+6; reads at 100,101,102,103.
- Zero weight: `wgt_in`=0, same taps → `res_data`=20.
- Vertical run:
  - Stimulus: `tap_stride`=128, `out_stride`=1, `num_out`=3.
  - Required: reads at base+{0,128,256,384}; `res_idx`=0,1,2 spaced 5 cycles apart; `done` with idx 2; total 16 cycles LOAD→done.
- Edge commands: `num_out`=0 → `done` one cycle after `start`, `mem_ren` never asserted. `start` while busy → no effect on the run.
- Wrap-around: `src_addr`=16382, `tap_stride`=1 → reads at 16382, 16383, 0, 1.
- Abort: reset asserted at TAP cnt=3 → all outputs 0 and `eng_cnt`=5 immediately; a new `start` then runs cleanly.
